// File: rtl/axi_master_arb.sv
// axi_master_arb
// Two-port arbiter (port 0 = fetch, port 1 = data) in front of a single
// master command interface. One transaction is in flight at a time and
// walks IDLE -> ISSUE -> BUSY -> DONE. The winning request is latched in
// IDLE. The master sees a one-cycle M_access strobe in ISSUE. Completion
// status is gathered in BUSY, and the owner gets a one-cycle done pulse
// in DONE.
module axi_master_arb #(
    parameter int RR_EN      = 1,
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
) (
    input  logic                  ACLK,
    input  logic                  ARESETn,

    input  logic                  p0_req,
    input  logic                  p0_rd0_wr1,
    input  logic [ADDR_WIDTH-1:0] p0_addr,
    input  logic [DATA_WIDTH-1:0] p0_wdata,
    input  logic [3:0]            p0_wstrb,
    output logic                  p0_ack,
    output logic                  p0_done,
    output logic [DATA_WIDTH-1:0] p0_rdata,
    output logic [1:0]            p0_resp,

    input  logic                  p1_req,
    input  logic                  p1_rd0_wr1,
    input  logic [ADDR_WIDTH-1:0] p1_addr,
    input  logic [DATA_WIDTH-1:0] p1_wdata,
    input  logic [3:0]            p1_wstrb,
    output logic                  p1_ack,
    output logic                  p1_done,
    output logic [DATA_WIDTH-1:0] p1_rdata,
    output logic [1:0]            p1_resp,

    output logic                  M_access,
    output logic                  M_rd0_wr1,
    output logic [ADDR_WIDTH-1:0] M_addr,
    output logic [DATA_WIDTH-1:0] M_write_data,
    output logic [3:0]            M_write_strobe,

    input  logic                  ready_M,
    input  logic [DATA_WIDTH-1:0] read_data_M,
    input  logic                  read_data_valid_M,
    input  logic [1:0]            resp_M
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_BUSY  = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    state_t                r_state;
    state_t                w_state_next;

    logic [1:0]            w_req;
    logic                  w_winner;
    logic                  w_grant;
    logic                  w_finish;

    logic                  w_sel_rw;
    logic [ADDR_WIDTH-1:0] w_sel_addr;
    logic [DATA_WIDTH-1:0] w_sel_wdata;
    logic [3:0]            w_sel_wstrb;

    logic                  r_rr_ptr;
    logic                  r_owner;
    logic                  r_cmd_rw;
    logic [ADDR_WIDTH-1:0] r_cmd_addr;
    logic [DATA_WIDTH-1:0] r_cmd_wdata;
    logic [3:0]            r_cmd_wstrb;

    logic [DATA_WIDTH-1:0] r_rdata;
    logic [1:0]            r_resp;
    logic [DATA_WIDTH-1:0] w_rdata_acc;
    logic [1:0]            w_resp_acc;

    logic [1:0]            w_ack;
    logic                  w_m_access;
    logic                  w_done_pulse;

    assign w_req    = {p1_req, p0_req};
    assign w_grant  = (r_state == ST_IDLE) && ready_M && (|w_req);
    assign w_finish = (r_state == ST_BUSY) && ready_M;

    // Winner selection: a lone requester always wins. On a tie, the port
    // named by the round-robin pointer wins, or port 1 in fixed-priority mode.
    always_comb begin
        w_winner = 1'b0;
        if (w_req == 2'b11) begin
            if (RR_EN != 0) begin
                w_winner = r_rr_ptr;
            end else begin
                w_winner = 1'b1;
            end
        end else begin
            w_winner = w_req[1];
        end
    end

    // Route the winning port's command fields to the command registers.
    always_comb begin
        w_sel_rw    = p0_rd0_wr1;
        w_sel_addr  = p0_addr;
        w_sel_wdata = p0_wdata;
        w_sel_wstrb = p0_wstrb;
        if (w_winner) begin
            w_sel_rw    = p1_rd0_wr1;
            w_sel_addr  = p1_addr;
            w_sel_wdata = p1_wdata;
            w_sel_wstrb = p1_wstrb;
        end
    end

    // FSM state register.
    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // FSM next-state logic. BUSY waits on ready_M with no timeout.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE:  if (w_grant) w_state_next = ST_ISSUE;
            ST_ISSUE: w_state_next = ST_BUSY;
            ST_BUSY:  if (ready_M) w_state_next = ST_DONE;
            ST_DONE:  w_state_next = ST_IDLE;
            default:  w_state_next = ST_IDLE;
        endcase
    end

    // FSM outputs. The ack is gated by reset, so a request held during
    // reset never produces a spurious pulse.
    always_comb begin
        w_ack        = 2'b00;
        w_m_access   = 1'b0;
        w_done_pulse = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_grant && ARESETn) begin
                    w_ack = w_winner ? 2'b10 : 2'b01;
                end
            end
            ST_ISSUE: w_m_access   = 1'b1;
            ST_DONE:  w_done_pulse = 1'b1;
            default:  ;
        endcase
    end

    // Latch the winning command and its owner on ack. The fields then stay
    // frozen until the next ack, so the requester may change its inputs.
    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            r_owner     <= 1'b0;
            r_cmd_rw    <= 1'b0;
            r_cmd_addr  <= '0;
            r_cmd_wdata <= '0;
            r_cmd_wstrb <= '0;
        end else if (w_grant) begin
            r_owner     <= w_winner;
            r_cmd_rw    <= w_sel_rw;
            r_cmd_addr  <= w_sel_addr;
            r_cmd_wdata <= w_sel_wdata;
            r_cmd_wstrb <= w_sel_wstrb;
        end
    end

    // Round-robin pointer. It moves only on ack, and points at the port that
    // was not just granted.
    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            r_rr_ptr <= 1'b0;
        end else if (w_grant) begin
            r_rr_ptr <= ~w_winner;
        end
    end

    // Working status for this cycle. resp_M is OR-ed into the response on
    // every BUSY cycle. Because the register is cleared when ISSUE is
    // entered, this both captures the response that comes with read data
    // and keeps any error bit sticky.
    assign w_rdata_acc = read_data_valid_M ? read_data_M : r_rdata;
    assign w_resp_acc  = r_resp | resp_M;

    // Collect read data and response while BUSY; clear them on entry to ISSUE.
    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            r_rdata <= '0;
            r_resp  <= '0;
        end else if (w_grant) begin
            r_rdata <= '0;
            r_resp  <= '0;
        end else if (r_state == ST_BUSY) begin
            r_rdata <= w_rdata_acc;
            r_resp  <= w_resp_acc;
        end
    end

    // Per-port result registers. They are loaded as BUSY exits, so they are
    // valid alongside the done pulse, and they hold until that port's next
    // completion. A write always reports zero read data.
    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_port
            logic [DATA_WIDTH-1:0] r_port_rdata;
            logic [1:0]            r_port_resp;

            // Update this port's result only when it owns the finishing transaction.
            always_ff @(posedge ACLK or negedge ARESETn) begin
                if (!ARESETn) begin
                    r_port_rdata <= '0;
                    r_port_resp  <= '0;
                end else if (w_finish && (r_owner == 1'(gi))) begin
                    r_port_rdata <= r_cmd_rw ? '0 : w_rdata_acc;
                    r_port_resp  <= w_resp_acc;
                end
            end
        end
    endgenerate

    assign p0_ack         = w_ack[0];
    assign p1_ack         = w_ack[1];
    assign p0_done        = w_done_pulse & ~r_owner;
    assign p1_done        = w_done_pulse &  r_owner;
    assign p0_rdata       = g_port[0].r_port_rdata;
    assign p0_resp        = g_port[0].r_port_resp;
    assign p1_rdata       = g_port[1].r_port_rdata;
    assign p1_resp        = g_port[1].r_port_resp;

    assign M_access       = w_m_access;
    assign M_rd0_wr1      = r_cmd_rw;
    assign M_addr         = r_cmd_addr;
    assign M_write_data   = r_cmd_wdata;
    assign M_write_strobe = r_cmd_wstrb;

endmodule

// File: doc/axi_master_arb.md
AXI_MASTER_ARB -- requirements
Module: axi_master_arb

Interface
REQ-001 Parameter RR_EN, default 1, meaning 1 = round-robin arbitration and 0 = fixed priority with port 1 (data) always winning.
REQ-002 ACLK  input  1  clock for all logic.
REQ-003 ARESETn  input  1  reset; SHALL be asynchronous, active-low.
REQ-004 pN_req  input  1  request from port N (N=0 fetch, N=1 data).
REQ-005 pN_rd0_wr1  input  1  port N command: 0 = read, 1 = write.
REQ-006 pN_addr  input  `ADDR_WIDTH (32)  port N address.
REQ-007 pN_wdata  input  `DATA_WIDTH (32)  port N write data.
REQ-008 pN_wstrb  input  4  port N write strobe.
REQ-009 pN_ack  output  1  one-cycle pulse when the port N request is latched.
REQ-010 pN_done  output  1  one-cycle pulse when the port N transaction completes.
REQ-011 pN_rdata  output  `DATA_WIDTH  read data for port N, valid with pN_done.
REQ-012 pN_resp  output  2  AXI response for port N, valid with pN_done.
REQ-013 M_access, M_rd0_wr1, M_addr, M_write_data, M_write_strobe  outputs  1/1/32/32/4  master command.
REQ-014 ready_M, read_data_M, read_data_valid_M, resp_M  inputs  1/32/1/2  master status.

Function
REQ-015 FSM states SHALL be IDLE, ISSUE, BUSY and DONE.
REQ-016 IDLE: when ready_M=1 and any pN_req=1, the block SHALL select a winner, register its rd0_wr1/addr/wdata/wstrb and owner id, pulse that port's pN_ack, and go to ISSUE.
REQ-017 With RR_EN=1 and both ports requesting, the winner SHALL be the port not granted most recently; after reset, port 0 SHALL win the first tie.
REQ-018 With RR_EN=0 and both ports requesting, port 1 SHALL win.
REQ-019 ISSUE: M_access SHALL be 1 for exactly this one cycle; the next state SHALL be BUSY unconditionally.
REQ-020 M_rd0_wr1, M_addr, M_write_data and M_write_strobe SHALL come from the registered command and SHALL stay stable from ISSUE through DONE.
REQ-021 BUSY: when read_data_valid_M=1, the block SHALL capture read_data_M into the rdata register and resp_M into the resp register.
REQ-022 BUSY: in any cycle where resp_M is non-zero, the block SHALL OR resp_M into the resp register (sticky); the resp register SHALL clear on entry to ISSUE.
REQ-023 BUSY: when ready_M=1, the block SHALL go to DONE; otherwise it SHALL stay in BUSY, with no timeout.
REQ-024 DONE: the owner's pN_done SHALL pulse for one cycle with registered pN_rdata and pN_resp; the block SHALL then return to IDLE.
REQ-025 For writes, pN_rdata SHALL be 0.
REQ-026 The non-owner's pN_done SHALL stay 0.
REQ-027 pN_rdata and pN_resp SHALL hold their values until the next pN_done for the same port.
REQ-028 A request that loses arbitration, or arrives while not in IDLE, SHALL wait, with no ack, until a later IDLE cycle.
REQ-029 A port may drop or change req and fields after its ack.
REQ-030 A req held high SHALL be re-arbitrated in the IDLE cycle after DONE; minimum spacing is 4 cycles from ack to ack.
REQ-031 The round-robin pointer SHALL update only on ack.

Reset
REQ-032 On ARESETn=0, at any state including mid-transaction, the block SHALL go to IDLE and clear the command registers, all pN_ack, pN_done, pN_rdata, pN_resp and M_access to 0, and point round-robin to port 0.
REQ-033 No pN_done SHALL be generated for a transaction aborted by reset.

Verification
REQ-034 Port 0 read of 0x100, master returns 0xDEADBEEF with RRESP=0 -> p0_ack at cycle 0, M_access only at cycle 1, p0_done with p0_rdata=0xDEADBEEF and p0_resp=0.
REQ-035 Both ports held requesting with RR_EN=1 -> grant order 0,1,0,1 over 4 transactions; with RR_EN=0 -> order 1,1,1,1.
REQ-036 Port 1 write of 0x200/0x12345678/strb 0xF with BRESP=2 -> M_write_data stable until done, p1_done with p1_resp=2 and p1_rdata=0.
REQ-037 Port 0 requests while a port 1 transaction is in BUSY -> no p0_ack until IDLE, then p0_ack in the first IDLE cycle after p1_done.
REQ-038 ARESETn asserted in BUSY -> all outputs 0 immediately, no done pulse, and the next tie is won by port 0.
REQ-039 Port 1 changes p1_addr the cycle after p1_ack -> M_addr keeps the originally latched value.
